// File: rtl/srl2prl_rx_if.sv
// Bundle of the serial-in / parallel-out signals of srl2prl_rx.
// The slave modport is the receiver; the master modport is whoever drives the
// serial link and consumes the parallel words.
interface srl2prl_rx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             srl;
  logic             srl_valid;
  logic [WIDTH-1:0] prl_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;
  logic             frame_err;
  logic             clr_err;

  modport master (
    output srl,
    output srl_valid,
    output out_ready,
    output clr_err,
    input  prl_out,
    input  out_valid,
    input  busy,
    input  overrun,
    input  frame_err
  );

  modport slave (
    input  srl,
    input  srl_valid,
    input  out_ready,
    input  clr_err,
    output prl_out,
    output out_valid,
    output busy,
    output overrun,
    output frame_err
  );
endinterface

// File: rtl/srl2prl_rx.sv
// Serial-to-parallel receiver. Assembles WIDTH consecutive valid serial bits
// into a word, presents it through a one-entry valid/ready buffer, and keeps
// sticky overrun / framing error flags.
module srl2prl_rx #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input logic         clock,
  input logic         rst,
  srl2prl_rx_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  state_e           state_q;
  logic [CntW-1:0]  count_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] prl_q;
  logic             out_valid_q;
  logic             overrun_q;
  logic             frame_err_q;

  logic [WIDTH-1:0] shift_next;
  logic             last_bit;
  logic             word_done;
  logic             frame_set;
  logic             take;
  logic             load;
  logic             drop;

  // Shift register merged with the bit on srl this cycle.
  always_comb begin
    shift_next = shreg_q;
    if (MSB_FIRST != 0) begin
      shift_next = {shreg_q[WIDTH-2:0], bus.srl};
    end else begin
      shift_next = {bus.srl, shreg_q[WIDTH-1:1]};
    end
  end

  // Word completion, framing error and output-buffer decisions for this edge.
  always_comb begin
    last_bit  = (count_q == CntW'(WIDTH - 1));
    word_done = (state_q == StShift) && bus.srl_valid && last_bit;
    frame_set = (state_q == StShift) && !bus.srl_valid;
    take      = out_valid_q && bus.out_ready;
    // A completed word may replace a buffered one only if that one leaves now.
    load      = word_done && (!out_valid_q || bus.out_ready);
    drop      = word_done && out_valid_q && !bus.out_ready;
  end

  // Receive FSM with the output buffer and sticky flags, all registered.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      shreg_q     <= '0;
      prl_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.srl_valid) begin
            shreg_q <= shift_next;
            count_q <= CntW'(1);
            state_q <= StShift;
          end
        end
        StShift: begin
          if (bus.srl_valid) begin
            shreg_q <= shift_next;
            if (last_bit) begin
              count_q <= '0;
              state_q <= StIdle;
            end else begin
              count_q <= count_q + CntW'(1);
            end
          end else begin
            // Gap inside a word: throw the partial word away.
            shreg_q <= '0;
            count_q <= '0;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase

      if (load) begin
        prl_q       <= shift_next;
        out_valid_q <= 1'b1;
      end else if (take) begin
        out_valid_q <= 1'b0;
      end

      // Set beats clear when both happen on the same edge.
      overrun_q   <= drop | (overrun_q & ~bus.clr_err);
      frame_err_q <= frame_set | (frame_err_q & ~bus.clr_err);
    end
  end

  assign bus.prl_out   = prl_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == StShift);
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;

endmodule
